// File: rtl/lsu_pkg.sv
// Shared types, funct3 width codes and the request legality check for the
// load/store unit. Optional feature macro used by lsu_dmem: LSU_PERF_EN.
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ST_W,
    S_RMW_RD,
    S_RMW_WR,
    S_RESP
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // A request is illegal when misaligned for its width, when funct3 is not a
  // defined width code, or when a store asks for an unsigned width.
  function automatic logic isReqErr(input logic wen, input logic [2:0] funct3,
                                    input logic [1:0] byteOff);
    logic err;
    case (funct3)
      F3_B:    err = 1'b0;
      F3_H:    err = byteOff[0];
      F3_W:    err = (byteOff != 2'b00);
      F3_BU:   err = wen;
      F3_HU:   err = wen | byteOff[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend and store byte/halfword merge
// against a little-endian 32-bit memory word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_loadWord,
  input  logic [31:0] i_oldWord,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_byteOff,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_loadData,
  output logic [31:0] o_storeWord
);

  logic [31:0] w_shifted;

  assign w_shifted = i_loadWord >> {i_byteOff, 3'b000};

  // Pick the addressed lane and extend it according to the width code.
  always_comb begin
    o_loadData = 32'h0;
    case (i_funct3)
      F3_B:    o_loadData = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_H:    o_loadData = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_W:    o_loadData = i_loadWord;
      F3_BU:   o_loadData = {24'h0, w_shifted[7:0]};
      F3_HU:   o_loadData = {16'h0, w_shifted[15:0]};
      default: o_loadData = 32'h0;
    endcase
  end

  // Replace only the target byte or halfword lane of the previously read word.
  always_comb begin
    o_storeWord = i_oldWord;
    if (i_funct3 == F3_B) begin
      case (i_byteOff)
        2'd0: o_storeWord[7:0]   = i_wdata[7:0];
        2'd1: o_storeWord[15:8]  = i_wdata[7:0];
        2'd2: o_storeWord[23:16] = i_wdata[7:0];
        2'd3: o_storeWord[31:24] = i_wdata[7:0];
        default: o_storeWord = i_oldWord;
      endcase
    end else if (i_funct3 == F3_H) begin
      if (i_byteOff[1]) o_storeWord[31:16] = i_wdata[15:0];
      else              o_storeWord[15:0]  = i_wdata[15:0];
    end
  end

endmodule

// File: rtl/lsu_dmem.sv
// Load/store unit in front of the word-wide data port of unified memory.
// Byte/halfword stores are done as read-modify-write. Defining LSU_PERF_EN
// adds load/store response counters.
module lsu_dmem
  import lsu_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        io_req_valid,
  output logic        io_req_ready,
  input  logic        io_req_wen,
  input  logic [2:0]  io_req_funct3,
  input  logic [31:0] io_req_addr,
  input  logic [31:0] io_req_wdata,
  output logic        io_resp_valid,
  input  logic        io_resp_ready,
  output logic [31:0] io_resp_rdata,
  output logic        io_resp_err,
  output logic [31:0] io_dmem_addr,
  input  logic [31:0] io_dmem_rdata,
  output logic        io_dmem_wen,
  output logic [31:0] io_dmem_wdata
`ifdef LSU_PERF_EN
  ,
  output logic [31:0] io_perf_loads,
  output logic [31:0] io_perf_stores
`endif
);

  lsu_state_t  r_state, w_nextState;
  logic        r_wen;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_merge;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_reqErr;
  logic [31:0] w_loadData;
  logic [31:0] w_storeWord;

  assign w_accept = io_req_valid && (r_state == S_IDLE);
  assign w_reqErr = isReqErr(io_req_wen, io_req_funct3, io_req_addr[1:0]);

  lsu_align u_align (
    .i_loadWord  (io_dmem_rdata),
    .i_oldWord   (r_merge),
    .i_wdata     (r_wdata),
    .i_byteOff   (r_addr[1:0]),
    .i_funct3    (r_funct3),
    .o_loadData  (w_loadData),
    .o_storeWord (w_storeWord)
  );

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_nextState;
  end

  // Next-state selection; errors skip the memory entirely.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (io_req_valid) begin
          if (w_reqErr)                   w_nextState = S_RESP;
          else if (!io_req_wen)           w_nextState = S_LOAD;
          else if (io_req_funct3 == F3_W) w_nextState = S_ST_W;
          else                            w_nextState = S_RMW_RD;
        end
      end
      S_LOAD:   w_nextState = S_RESP;
      S_ST_W:   w_nextState = S_RESP;
      S_RMW_RD: w_nextState = S_RMW_WR;
      S_RMW_WR: w_nextState = S_RESP;
      S_RESP:   if (io_resp_ready) w_nextState = S_IDLE;
      default:  w_nextState = S_IDLE;
    endcase
  end

  // Request capture, load result and RMW merge word registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wen    <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_merge  <= 32'h0;
      r_rdata  <= 32'h0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wen    <= io_req_wen;
        r_funct3 <= io_req_funct3;
        r_addr   <= io_req_addr;
        r_wdata  <= io_req_wdata;
        r_rdata  <= 32'h0;
        r_err    <= w_reqErr;
      end
      if (r_state == S_LOAD)   r_rdata <= w_loadData;
      if (r_state == S_RMW_RD) r_merge <= io_dmem_rdata;
    end
  end

  // Handshake and write strobes come from the state register alone.
  always_comb begin
    io_req_ready  = (r_state == S_IDLE);
    io_resp_valid = (r_state == S_RESP);
    io_dmem_wen   = (r_state == S_ST_W) || (r_state == S_RMW_WR);
    io_dmem_wdata = 32'h0;
    if (r_state == S_ST_W)        io_dmem_wdata = r_wdata;
    else if (r_state == S_RMW_WR) io_dmem_wdata = w_storeWord;
  end

  assign io_dmem_addr  = {r_addr[31:2], 2'b00};
  assign io_resp_rdata = r_rdata;
  assign io_resp_err   = r_err;

`ifdef LSU_PERF_EN
  logic w_respDone;
  assign w_respDone = (r_state == S_RESP) && io_resp_ready && !r_err;

  // Count successful load and store responses; errors are not counted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      io_perf_loads  <= 32'h0;
      io_perf_stores <= 32'h0;
    end else if (w_respDone) begin
      if (r_wen) io_perf_stores <= io_perf_stores + 32'd1;
      else       io_perf_loads  <= io_perf_loads + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lsu_dmem.sv
// Directed bench for lsu_dmem with a small word memory model on the data port.
module tb_lsu_dmem;

  logic        clock;
  logic        reset_n;
  logic        io_req_valid;
  logic        io_req_ready;
  logic        io_req_wen;
  logic [2:0]  io_req_funct3;
  logic [31:0] io_req_addr;
  logic [31:0] io_req_wdata;
  logic        io_resp_valid;
  logic        io_resp_ready;
  logic [31:0] io_resp_rdata;
  logic        io_resp_err;
  logic [31:0] io_dmem_addr;
  logic [31:0] io_dmem_rdata;
  logic        io_dmem_wen;
  logic [31:0] io_dmem_wdata;
`ifdef LSU_PERF_EN
  logic [31:0] io_perf_loads;
  logic [31:0] io_perf_stores;
`endif

  logic [31:0] mem [0:255];
  int          cyc;
  int          wenCount;
  int          lastWenCyc;
  logic [31:0] lastWenData;

  int          checkCount;
  int          passCount;
  int          acceptCyc;
  int          respLat;
  int          wenBefore;
  logic        stableOk;
  logic [31:0] heldData;

  lsu_dmem dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .io_req_valid  (io_req_valid),
    .io_req_ready  (io_req_ready),
    .io_req_wen    (io_req_wen),
    .io_req_funct3 (io_req_funct3),
    .io_req_addr   (io_req_addr),
    .io_req_wdata  (io_req_wdata),
    .io_resp_valid (io_resp_valid),
    .io_resp_ready (io_resp_ready),
    .io_resp_rdata (io_resp_rdata),
    .io_resp_err   (io_resp_err),
    .io_dmem_addr  (io_dmem_addr),
    .io_dmem_rdata (io_dmem_rdata),
    .io_dmem_wen   (io_dmem_wen),
    .io_dmem_wdata (io_dmem_wdata)
`ifdef LSU_PERF_EN
    ,
    .io_perf_loads (io_perf_loads),
    .io_perf_stores(io_perf_stores)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign io_dmem_rdata = mem[io_dmem_addr[9:2]];

  // Memory model: full-word write on each enabled edge, recording when and what.
  always @(posedge clock) begin
    if (io_dmem_wen) begin
      mem[io_dmem_addr[9:2]] <= io_dmem_wdata;
      wenCount    = wenCount + 1;
      lastWenCyc  = cyc;
      lastWenData = io_dmem_wdata;
    end
    cyc = cyc + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present a request just after a falling edge, let it be accepted, then
  // wait (bounded) for the response; returns positioned at a falling edge.
  task automatic applyStimulus(input logic wen, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata);
    io_req_valid  = 1'b1;
    io_req_wen    = wen;
    io_req_funct3 = f3;
    io_req_addr   = addr;
    io_req_wdata  = wdata;
    wenBefore     = wenCount;
    @(posedge clock);
    #1;
    acceptCyc    = cyc - 1;
    io_req_valid = 1'b0;
    respLat      = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (io_resp_valid) begin
        respLat = cyc - acceptCyc;
        break;
      end
    end
  endtask

  task automatic finishResp();
    io_resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    cyc = 0;
    wenCount = 0;
    lastWenCyc = 0;
    lastWenData = 32'h0;
    checkCount = 0;
    passCount = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[64] = 32'h8899AABB;

    reset_n       = 1'b0;
    io_req_valid  = 1'b0;
    io_req_wen    = 1'b0;
    io_req_funct3 = 3'b000;
    io_req_addr   = 32'h0;
    io_req_wdata  = 32'h0;
    io_resp_ready = 1'b1;

    repeat (2) @(negedge clock);
    checkOutput("rst_req_ready", {31'h0, io_req_ready}, 32'h1);
    checkOutput("rst_resp_valid", {31'h0, io_resp_valid}, 32'h0);
    checkOutput("rst_rdata", io_resp_rdata, 32'h0);
    checkOutput("rst_err", {31'h0, io_resp_err}, 32'h0);
    checkOutput("rst_dmem_wen", {31'h0, io_dmem_wen}, 32'h0);
    checkOutput("rst_dmem_addr", io_dmem_addr, 32'h0);
    checkOutput("rst_dmem_wdata", io_dmem_wdata, 32'h0);
    reset_n = 1'b1;
    @(negedge clock);
    $display("[TB] reset released");

    applyStimulus(1'b0, 3'b000, 32'h101, 32'h0);
    checkOutput("lb_rdata", io_resp_rdata, 32'hFFFFFFAA);
    checkOutput("lb_err", {31'h0, io_resp_err}, 32'h0);
    checkOutput("lb_latency", respLat, 32'd2);
    checkOutput("lb_dmem_addr", io_dmem_addr, 32'h100);
    finishResp();

    applyStimulus(1'b0, 3'b100, 32'h103, 32'h0);
    checkOutput("lbu_rdata", io_resp_rdata, 32'h00000088);
    finishResp();

    applyStimulus(1'b0, 3'b001, 32'h102, 32'h0);
    checkOutput("lh_rdata", io_resp_rdata, 32'hFFFF8899);
    finishResp();

    applyStimulus(1'b0, 3'b101, 32'h100, 32'h0);
    checkOutput("lhu_rdata", io_resp_rdata, 32'h0000AABB);
    finishResp();

    applyStimulus(1'b0, 3'b010, 32'h100, 32'h0);
    checkOutput("lw_rdata", io_resp_rdata, 32'h8899AABB);
    checkOutput("lw_no_wen", wenCount - wenBefore, 32'd0);
    finishResp();

    applyStimulus(1'b1, 3'b000, 32'h102, 32'h12345655);
    checkOutput("sb_latency", respLat, 32'd3);
    checkOutput("sb_wen_count", wenCount - wenBefore, 32'd1);
    checkOutput("sb_wen_cycle", lastWenCyc - acceptCyc, 32'd2);
    checkOutput("sb_wdata", lastWenData, 32'h8855AABB);
    checkOutput("sb_rdata", io_resp_rdata, 32'h0);
    checkOutput("sb_err", {31'h0, io_resp_err}, 32'h0);
    finishResp();

    applyStimulus(1'b0, 3'b010, 32'h100, 32'h0);
    checkOutput("lw_after_sb", io_resp_rdata, 32'h8855AABB);
    finishResp();

    applyStimulus(1'b1, 3'b010, 32'h104, 32'hDEADBEEF);
    checkOutput("sw_latency", respLat, 32'd2);
    checkOutput("sw_wen_cycle", lastWenCyc - acceptCyc, 32'd1);
    checkOutput("sw_wen_count", wenCount - wenBefore, 32'd1);
    checkOutput("sw_wdata", lastWenData, 32'hDEADBEEF);
    finishResp();

    applyStimulus(1'b1, 3'b001, 32'h106, 32'h0000CAFE);
    checkOutput("sh_hi_wdata", lastWenData, 32'hCAFEBEEF);
    finishResp();

    applyStimulus(1'b0, 3'b001, 32'h106, 32'h0);
    checkOutput("lh_hi_rdata", io_resp_rdata, 32'hFFFFCAFE);
    finishResp();

    applyStimulus(1'b0, 3'b010, 32'h102, 32'h0);
    checkOutput("lw_mis_err", {31'h0, io_resp_err}, 32'h1);
    checkOutput("lw_mis_rdata", io_resp_rdata, 32'h0);
    checkOutput("lw_mis_latency", respLat, 32'd1);
    checkOutput("lw_mis_no_wen", wenCount - wenBefore, 32'd0);
    finishResp();

    applyStimulus(1'b1, 3'b001, 32'h101, 32'h00001111);
    checkOutput("sh_mis_err", {31'h0, io_resp_err}, 32'h1);
    finishResp();
    checkOutput("sh_mis_no_wen", wenCount - wenBefore, 32'd0);
    checkOutput("sh_mis_mem", mem[64], 32'h8855AABB);

    applyStimulus(1'b0, 3'b011, 32'h100, 32'h0);
    checkOutput("f3_illegal_err", {31'h0, io_resp_err}, 32'h1);
    finishResp();

    applyStimulus(1'b1, 3'b100, 32'h100, 32'h0);
    checkOutput("sbu_err", {31'h0, io_resp_err}, 32'h1);
    finishResp();
    checkOutput("sbu_no_wen", wenCount - wenBefore, 32'd0);

    applyStimulus(1'b1, 3'b000, 32'h102, 32'h00000099);
    checkOutput("sb_restore_wdata", lastWenData, 32'h8899AABB);
    finishResp();

    io_resp_ready = 1'b0;
    applyStimulus(1'b0, 3'b000, 32'h101, 32'h0);
    checkOutput("bp_first_rdata", io_resp_rdata, 32'hFFFFFFAA);
    heldData = io_resp_rdata;
    stableOk = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (!io_resp_valid || io_req_ready || io_resp_rdata !== heldData) stableOk = 1'b0;
    end
    checkOutput("bp_stable", {31'h0, stableOk}, 32'h1);
    finishResp();
    checkOutput("bp_idle_ready", {31'h0, io_req_ready}, 32'h1);
    checkOutput("bp_idle_valid", {31'h0, io_resp_valid}, 32'h0);

    io_req_valid  = 1'b1;
    io_req_wen    = 1'b1;
    io_req_funct3 = 3'b001;
    io_req_addr   = 32'h100;
    io_req_wdata  = 32'h00007777;
    wenBefore     = wenCount;
    @(posedge clock);
    #2;
    io_req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_wen", {31'h0, io_dmem_wen}, 32'h0);
    checkOutput("mid_rst_ready", {31'h0, io_req_ready}, 32'h1);
    checkOutput("mid_rst_valid", {31'h0, io_resp_valid}, 32'h0);
    checkOutput("mid_rst_addr", io_dmem_addr, 32'h0);
    checkOutput("mid_rst_wdata", io_dmem_wdata, 32'h0);
    checkOutput("mid_rst_rdata", io_resp_rdata, 32'h0);
    checkOutput("mid_rst_err", {31'h0, io_resp_err}, 32'h0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("mid_rst_no_wen", wenCount - wenBefore, 32'd0);
    checkOutput("mid_rst_mem", mem[64], 32'h8899AABB);
    checkOutput("mid_rst_no_resp", {31'h0, io_resp_valid}, 32'h0);
`ifdef LSU_PERF_EN
    checkOutput("perf_loads_rst", io_perf_loads, 32'h0);
    checkOutput("perf_stores_rst", io_perf_stores, 32'h0);
`endif

    applyStimulus(1'b0, 3'b010, 32'h100, 32'h0);
    checkOutput("lw_post_rst", io_resp_rdata, 32'h8899AABB);
    finishResp();
    applyStimulus(1'b1, 3'b010, 32'h108, 32'h11223344);
    finishResp();
    checkOutput("sw_post_rst_mem", mem[66], 32'h11223344);
`ifdef LSU_PERF_EN
    checkOutput("perf_loads", io_perf_loads, 32'h1);
    checkOutput("perf_stores", io_perf_stores, 32'h1);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
